// File: rtl/vdp_cmd_access_pacer.sv
// VDP command-engine VRAM access pacer.
// Starts one VRAM access per command request while the wait controller's
// ACTIVE throttle is high, arbitrates it onto the VRAM slot interface and
// returns one CMD_ACK plus one DRIVE pulse per completed access. Reads that
// never see VRAM_RVALID are force-completed after RD_TIMEOUT wait cycles with
// data 8'hFF and a sticky TIMEOUT_ERR.
// Optional build macro VDP_ACCESS_STATS_EN adds the STALL_CNT output, which
// counts cycles a request was held off by ACTIVE = 0.
module vdp_cmd_access_pacer #(
  parameter int unsigned RD_TIMEOUT = 15
) (
  input  logic        CLK21M,
  input  logic        RESET_N,
  input  logic        ACTIVE,
  input  logic        CMD_REQ,
  input  logic        CMD_WR,
  input  logic [16:0] CMD_ADDR,
  input  logic [7:0]  CMD_WDATA,
  output logic        CMD_ACK,
  output logic [7:0]  CMD_RDATA,
  output logic        VRAM_REQ,
  input  logic        VRAM_GNT,
  output logic [16:0] VRAM_ADDR,
  output logic        VRAM_WE,
  output logic [7:0]  VRAM_WDATA,
  input  logic [7:0]  VRAM_RDATA,
  input  logic        VRAM_RVALID,
  output logic        DRIVE,
  output logic        BUSY,
  output logic        TIMEOUT_ERR,
  input  logic        CLR_ERR
`ifdef VDP_ACCESS_STATS_EN
  ,
  output logic [15:0] STALL_CNT
`endif
);

  typedef enum logic [1:0] {StIdle, StReq, StWaitRd, StAck} state_e;

  // Counter value at which a read is force-completed.
  localparam logic [7:0] TimeoutLast = 8'(RD_TIMEOUT);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        ack_q;
  logic        drive_q;
  logic        busy_q;
  logic        err_q;
  logic        vram_req_q;
  logic        we_q;
  logic [16:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;

  // Access FSM with registered outputs; ACK/DRIVE are raised on entry to StAck.
  always_ff @(posedge CLK21M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      ack_q      <= 1'b0;
      drive_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      vram_req_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 17'd0;
      wdata_q    <= 8'd0;
      rdata_q    <= 8'd0;
    end else begin
      ack_q   <= 1'b0;
      drive_q <= 1'b0;
      // A timeout set below in the same cycle overrides this clear.
      if (CLR_ERR) begin
        err_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (CMD_REQ && ACTIVE) begin
            state_q    <= StReq;
            busy_q     <= 1'b1;
            vram_req_q <= 1'b1;
            we_q       <= CMD_WR;
            addr_q     <= CMD_ADDR;
            wdata_q    <= CMD_WDATA;
          end
        end
        StReq: begin
          if (VRAM_GNT) begin
            vram_req_q <= 1'b0;
            cnt_q      <= 8'd0;
            if (we_q) begin
              state_q <= StAck;
              ack_q   <= 1'b1;
              drive_q <= 1'b1;
            end else begin
              state_q <= StWaitRd;
            end
          end
        end
        StWaitRd: begin
          if (VRAM_RVALID) begin
            rdata_q <= VRAM_RDATA;
            state_q <= StAck;
            ack_q   <= 1'b1;
            drive_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q + 8'd1 == TimeoutLast) begin
              rdata_q <= 8'hFF;
              err_q   <= 1'b1;
              state_q <= StAck;
              ack_q   <= 1'b1;
              drive_q <= 1'b1;
            end
          end
        end
        StAck: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign CMD_ACK     = ack_q;
  assign DRIVE       = drive_q;
  assign BUSY        = busy_q;
  assign TIMEOUT_ERR = err_q;
  assign VRAM_REQ    = vram_req_q;
  assign VRAM_WE     = we_q;
  assign VRAM_ADDR   = addr_q;
  assign VRAM_WDATA  = wdata_q;
  assign CMD_RDATA   = rdata_q;

`ifdef VDP_ACCESS_STATS_EN
  logic [15:0] stall_q;

  // Saturating count of IDLE cycles where a request is held off by the throttle.
  always_ff @(posedge CLK21M or negedge RESET_N) begin
    if (!RESET_N) begin
      stall_q <= 16'd0;
    end else if (CLR_ERR) begin
      stall_q <= 16'd0;
    end else if (state_q == StIdle && CMD_REQ && !ACTIVE && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign STALL_CNT = stall_q;
`endif

endmodule

// File: tb/tb_vdp_cmd_access_pacer.sv
// Self-checking bench for vdp_cmd_access_pacer. Expected timing comes from
// access-level latency arithmetic (request cycles, read wait, ACK cycle).
module tb_vdp_cmd_access_pacer;

  localparam int RD_TO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ACTIVE = 1'b0;
  logic        CMD_REQ = 1'b0;
  logic        CMD_WR = 1'b0;
  logic [16:0] CMD_ADDR = '0;
  logic [7:0]  CMD_WDATA = '0;
  logic        CMD_ACK;
  logic [7:0]  CMD_RDATA;
  logic        VRAM_REQ;
  logic        VRAM_GNT = 1'b0;
  logic [16:0] VRAM_ADDR;
  logic        VRAM_WE;
  logic [7:0]  VRAM_WDATA;
  logic [7:0]  VRAM_RDATA = '0;
  logic        VRAM_RVALID = 1'b0;
  logic        DRIVE;
  logic        BUSY;
  logic        TIMEOUT_ERR;
  logic        CLR_ERR = 1'b0;
`ifdef VDP_ACCESS_STATS_EN
  logic [15:0] STALL_CNT;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0]  last_rdata;
  logic        err_exp;
  logic [15:0] stall_exp;

  always #5 clk = ~clk;

  vdp_cmd_access_pacer #(.RD_TIMEOUT(RD_TO)) dut (
    .CLK21M      (clk),
    .RESET_N     (rst_n),
    .ACTIVE      (ACTIVE),
    .CMD_REQ     (CMD_REQ),
    .CMD_WR      (CMD_WR),
    .CMD_ADDR    (CMD_ADDR),
    .CMD_WDATA   (CMD_WDATA),
    .CMD_ACK     (CMD_ACK),
    .CMD_RDATA   (CMD_RDATA),
    .VRAM_REQ    (VRAM_REQ),
    .VRAM_GNT    (VRAM_GNT),
    .VRAM_ADDR   (VRAM_ADDR),
    .VRAM_WE     (VRAM_WE),
    .VRAM_WDATA  (VRAM_WDATA),
    .VRAM_RDATA  (VRAM_RDATA),
    .VRAM_RVALID (VRAM_RVALID),
    .DRIVE       (DRIVE),
    .BUSY        (BUSY),
    .TIMEOUT_ERR (TIMEOUT_ERR),
    .CLR_ERR     (CLR_ERR)
`ifdef VDP_ACCESS_STATS_EN
    ,
    .STALL_CNT   (STALL_CNT)
`endif
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One access accepted in the current (IDLE) cycle = cycle 0. g = extra REQ
  // cycles before grant, rv = WAIT_RD cycle carrying RVALID (0 = never),
  // clr_cyc = cycle with CLR_ERR high (<1 = none).
  task automatic run_access(input logic wr, input logic [16:0] addr, input logic [7:0] wd,
                            input int g, input int rv, input logic [7:0] rd,
                            input logic drop_act, input int clr_cyc);
    int req_end, wait_n, ack_cyc, clr;
    logic to;
    logic [7:0] exp_rd, exp_cur;
    req_end = 1 + g;
    wait_n  = 0;
    to      = 1'b0;
    if (!wr) begin
      if (rv >= 1 && rv <= RD_TO) wait_n = rv;
      else begin
        wait_n = RD_TO;
        to     = 1'b1;
      end
    end
    ack_cyc = req_end + wait_n + 1;
    exp_rd  = wr ? last_rdata : (to ? 8'hFF : rd);
    clr     = (clr_cyc >= 1 && clr_cyc <= ack_cyc) ? clr_cyc : -1;
    CMD_REQ = 1'b1; ACTIVE = 1'b1; CMD_WR = wr; CMD_ADDR = addr; CMD_WDATA = wd;
    VRAM_GNT = 1'b0; VRAM_RVALID = 1'b0; CLR_ERR = 1'b0;
    for (int c = 1; c <= ack_cyc + 1; c++) begin
      next_cycle();
      exp_cur = (c >= ack_cyc) ? exp_rd : last_rdata;
      checks++;
      if (VRAM_REQ !== (c <= req_end)) begin
        errors++; $display("FAIL vram_req c=%0d: got %b want %b", c, VRAM_REQ, c <= req_end);
      end
      checks++;
      if (CMD_ACK !== (c == ack_cyc)) begin
        errors++; $display("FAIL cmd_ack c=%0d: got %b want %b", c, CMD_ACK, c == ack_cyc);
      end
      checks++;
      if (DRIVE !== (c == ack_cyc)) begin
        errors++; $display("FAIL drive c=%0d: got %b want %b", c, DRIVE, c == ack_cyc);
      end
      checks++;
      if (BUSY !== (c <= ack_cyc)) begin
        errors++; $display("FAIL busy c=%0d: got %b want %b", c, BUSY, c <= ack_cyc);
      end
      checks++;
      if (CMD_RDATA !== exp_cur) begin
        errors++; $display("FAIL cmd_rdata c=%0d: got %h want %h", c, CMD_RDATA, exp_cur);
      end
      checks++;
      if (TIMEOUT_ERR !== err_exp) begin
        errors++; $display("FAIL timeout_err c=%0d: got %b want %b", c, TIMEOUT_ERR, err_exp);
      end
`ifdef VDP_ACCESS_STATS_EN
      checks++;
      if (STALL_CNT !== stall_exp) begin
        errors++; $display("FAIL stall_cnt c=%0d: got %0d want %0d", c, STALL_CNT, stall_exp);
      end
`endif
      if (c <= req_end) begin
        checks++;
        if (VRAM_ADDR !== addr || VRAM_WE !== wr || VRAM_WDATA !== wd) begin
          errors++;
          $display("FAIL vram_latch c=%0d: got %h/%b/%h want %h/%b/%h", c, VRAM_ADDR, VRAM_WE,
                   VRAM_WDATA, addr, wr, wd);
        end
      end
      // Inputs for cycle c; CMD_* and ACTIVE are noise while busy.
      CMD_REQ   = (c <= ack_cyc) ? 1'($urandom) : 1'b0;
      CMD_WR    = 1'($urandom);
      CMD_ADDR  = 17'($urandom);
      CMD_WDATA = 8'($urandom);
      ACTIVE    = drop_act ? 1'b0 : 1'($urandom);
      VRAM_GNT  = (c == req_end) ? 1'b1 : ((c > req_end) ? 1'($urandom) : 1'b0);
      if (!wr && rv >= 1 && c == req_end + rv) begin
        VRAM_RVALID = 1'b1; VRAM_RDATA = rd;
      end else if (c <= req_end || c > req_end + wait_n) begin
        VRAM_RVALID = 1'($urandom); VRAM_RDATA = 8'($urandom);
      end else begin
        VRAM_RVALID = 1'b0; VRAM_RDATA = 8'($urandom);
      end
      CLR_ERR = (c == clr);
      if (to && c == req_end + wait_n) err_exp = 1'b1;
      else if (c == clr) err_exp = 1'b0;
      if (c == clr) stall_exp = 16'd0;
    end
    last_rdata = exp_rd;
    VRAM_GNT = 1'b0; VRAM_RVALID = 1'b0; CLR_ERR = 1'b0; ACTIVE = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    checks++;
    if ({CMD_ACK, VRAM_REQ, VRAM_WE, DRIVE, BUSY, TIMEOUT_ERR} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000",
                         {CMD_ACK, VRAM_REQ, VRAM_WE, DRIVE, BUSY, TIMEOUT_ERR});
    end
    checks++;
    if (CMD_RDATA !== 8'h00 || VRAM_ADDR !== 17'h0 || VRAM_WDATA !== 8'h00) begin
      errors++; $display("FAIL reset_data: got %h/%h/%h want 0/0/0", CMD_RDATA, VRAM_ADDR,
                         VRAM_WDATA);
    end
`ifdef VDP_ACCESS_STATS_EN
    checks++;
    if (STALL_CNT !== 16'd0) begin
      errors++; $display("FAIL reset_stall: got %0d want 0", STALL_CNT);
    end
`endif
    last_rdata = 8'h00; err_exp = 1'b0; stall_exp = 16'd0;
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_write();
    run_access(1'b1, 17'h1ABCD, 8'h5A, 0, 0, 8'h00, 1'b0, -1);
  endtask

  task automatic test_throttle();
    CMD_REQ = 1'b0; CLR_ERR = 1'b1;
    next_cycle();
    CLR_ERR = 1'b0; err_exp = 1'b0; stall_exp = 16'd0;
    for (int i = 0; i < 10; i++) begin
      CMD_REQ = 1'b1; ACTIVE = 1'b0; CMD_WR = 1'($urandom);
      next_cycle();
      stall_exp = stall_exp + 16'd1;
      checks++;
      if (VRAM_REQ !== 1'b0 || BUSY !== 1'b0) begin
        errors++; $display("FAIL throttle_hold i=%0d: got req=%b busy=%b want 0/0", i, VRAM_REQ,
                           BUSY);
      end
`ifdef VDP_ACCESS_STATS_EN
      checks++;
      if (STALL_CNT !== stall_exp) begin
        errors++; $display("FAIL throttle_stall i=%0d: got %0d want %0d", i, STALL_CNT, stall_exp);
      end
`endif
    end
    // ACTIVE held low for the whole access once accepted.
    run_access(1'b1, 17'h00ACE, 8'h81, 2, 0, 8'h00, 1'b1, -1);
  endtask

  task automatic test_read();
    run_access(1'b0, 17'h00123, 8'h00, 3, 3, 8'hC3, 1'b0, -1);
  endtask

  task automatic test_timeout();
    run_access(1'b0, 17'h0BEEF, 8'h11, 1, 0, 8'h00, 1'b0, -1);
    for (int i = 0; i < 5; i++) begin
      CMD_REQ = 1'b0;
      next_cycle();
      checks++;
      if (TIMEOUT_ERR !== 1'b1) begin
        errors++; $display("FAIL err_sticky i=%0d: got %b want 1", i, TIMEOUT_ERR);
      end
    end
    CLR_ERR = 1'b1;
    next_cycle();
    CLR_ERR = 1'b0; err_exp = 1'b0; stall_exp = 16'd0;
    checks++;
    if (TIMEOUT_ERR !== 1'b0) begin
      errors++; $display("FAIL err_clear: got %b want 0", TIMEOUT_ERR);
    end
    // RVALID on the final wait cycle beats the timeout.
    run_access(1'b0, 17'h10001, 8'h22, 0, RD_TO, 8'h3C, 1'b0, -1);
    // Timeout and CLR_ERR in the same cycle: the set wins.
    run_access(1'b0, 17'h10002, 8'h33, 2, 0, 8'h00, 1'b0, 1 + 2 + RD_TO);
    CLR_ERR = 1'b1;
    next_cycle();
    CLR_ERR = 1'b0; err_exp = 1'b0; stall_exp = 16'd0;
  endtask

  task automatic test_reset_mid_read();
    CMD_REQ = 1'b1; ACTIVE = 1'b1; CMD_WR = 1'b0; CMD_ADDR = 17'h0F0F0; CMD_WDATA = 8'hA5;
    next_cycle();
    CMD_REQ = 1'b0; VRAM_GNT = 1'b1;
    next_cycle();
    VRAM_GNT = 1'b0;
    next_cycle();
    checks++;
    if (BUSY !== 1'b1) begin
      errors++; $display("FAIL midread_busy: got %b want 1", BUSY);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({CMD_ACK, VRAM_REQ, VRAM_WE, DRIVE, BUSY, TIMEOUT_ERR} !== 6'b0 ||
        CMD_RDATA !== 8'h00 || VRAM_ADDR !== 17'h0 || VRAM_WDATA !== 8'h00) begin
      errors++; $display("FAIL midread_async_reset: got flags=%b addr=%h want all 0",
                         {CMD_ACK, VRAM_REQ, VRAM_WE, DRIVE, BUSY, TIMEOUT_ERR}, VRAM_ADDR);
    end
    last_rdata = 8'h00; err_exp = 1'b0; stall_exp = 16'd0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      VRAM_RVALID = 1'b1; VRAM_RDATA = 8'h77; ACTIVE = 1'($urandom);
      next_cycle();
      checks++;
      if (CMD_ACK !== 1'b0 || DRIVE !== 1'b0 || BUSY !== 1'b0 || CMD_RDATA !== 8'h00) begin
        errors++; $display("FAIL post_reset_quiet i=%0d: got ack=%b drive=%b busy=%b rdata=%h",
                           i, CMD_ACK, DRIVE, BUSY, CMD_RDATA);
      end
    end
    VRAM_RVALID = 1'b0;
    run_access(1'b1, 17'h05555, 8'hE7, 1, 0, 8'h00, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    int acks, drives;
    acks = 0; drives = 0;
    CMD_REQ = 1'b1; ACTIVE = 1'b1; CMD_WR = 1'b1; VRAM_GNT = 1'b1;
    CMD_ADDR = 17'h00100; CMD_WDATA = 8'd1;
    for (int c = 1; c <= 26; c++) begin
      next_cycle();
      checks++;
      if (CMD_ACK !== ((c % 3 == 2) && (c <= 23))) begin
        errors++; $display("FAIL stream_ack c=%0d: got %b", c, CMD_ACK);
      end
      checks++;
      if (DRIVE !== CMD_ACK) begin
        errors++; $display("FAIL stream_drive c=%0d: got %b want %b", c, DRIVE, CMD_ACK);
      end
      if (CMD_ACK === 1'b1) acks++;
      if (DRIVE === 1'b1) drives++;
      if (c % 3 == 1 && c <= 22) begin
        checks++;
        if (VRAM_REQ !== 1'b1 || VRAM_WDATA !== 8'((c - 1) * 7 + 1)) begin
          errors++; $display("FAIL stream_req c=%0d: got req=%b wdata=%h want 1/%h", c, VRAM_REQ,
                             VRAM_WDATA, 8'((c - 1) * 7 + 1));
        end
      end
      CMD_REQ   = (c <= 21);
      CMD_WDATA = 8'(c * 7 + 1);
    end
    VRAM_GNT = 1'b0; CMD_REQ = 1'b0;
    checks++;
    if (acks != 8 || drives != 8) begin
      errors++; $display("FAIL stream_count: got acks=%0d drives=%0d want 8/8", acks, drives);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int i = 0; i < gap; i++) begin
        CMD_REQ = 1'b0; ACTIVE = 1'($urandom);
        next_cycle();
        checks++;
        if (BUSY !== 1'b0 || CMD_ACK !== 1'b0) begin
          errors++; $display("FAIL rand_gap n=%0d: got busy=%b ack=%b want 0/0", n, BUSY, CMD_ACK);
        end
      end
      run_access(1'($urandom), 17'($urandom), 8'($urandom), int'($urandom_range(0, 4)),
                 int'($urandom_range(0, RD_TO + 2)), 8'($urandom), 1'($urandom),
                 int'($urandom_range(0, 25)));
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_throttle();
    test_read();
    test_timeout();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vdp_cmd_access_pacer.md
Name: vdp_cmd_access_pacer

Overview:
Paces VRAM accesses issued by the VDP command engine. A new access starts only while the wait controller's ACTIVE throttle is high. The block arbitrates each access onto the VRAM slot interface and returns a one-cycle DRIVE pulse per completed access, which advances the wait controller's credit accumulator. It sits between the command engine, the wait controller and the VRAM slot arbiter.

Parameters:
RD_TIMEOUT, 15, number of WAIT_RD cycles without VRAM_RVALID before a read is force-completed (range 1..255).

Ports:
CLK21M  in  1  system clock (21.48 MHz)
RESET_N  in  1  asynchronous active-low reset
ACTIVE  in  1  throttle from wait controller; 1 = an access may start
CMD_REQ  in  1  command engine requests one VRAM access (level)
CMD_WR  in  1  1 = write, 0 = read; sampled with CMD_REQ
CMD_ADDR  in  17  VRAM byte address
CMD_WDATA  in  8  write data
CMD_ACK  out  1  one-cycle pulse: access complete
CMD_RDATA  out  8  read data; valid from the CMD_ACK cycle until the next CMD_ACK
VRAM_REQ  out  1  slot request; held until VRAM_GNT
VRAM_GNT  in  1  slot granted in this cycle
VRAM_ADDR  out  17  latched address
VRAM_WE  out  1  latched write flag
VRAM_WDATA  out  8  latched write data
VRAM_RDATA  in  8  read data
VRAM_RVALID  in  1  VRAM_RDATA valid
DRIVE  out  1  one-cycle pulse to wait controller per completed access
BUSY  out  1  1 in every state except IDLE
TIMEOUT_ERR  out  1  sticky read-timeout flag
CLR_ERR  in  1  synchronous clear of TIMEOUT_ERR (and stall counter)

Behaviour:
- Reset values: state IDLE. CMD_ACK, VRAM_REQ, VRAM_WE, DRIVE, BUSY and TIMEOUT_ERR are 0. CMD_RDATA, VRAM_ADDR and VRAM_WDATA are 0. Timeout counter is 0.
- Reset is asynchronous and may be asserted in any state. Reset mid-access abandons the access with no ACK and no DRIVE.
- FSM states: IDLE, REQ, WAIT_RD, ACK.
- IDLE:
  - If CMD_REQ & ACTIVE, latch CMD_WR, CMD_ADDR and CMD_WDATA, then go to REQ.
  - If ACTIVE = 0, stay in IDLE regardless of CMD_REQ.
  - ACTIVE is sampled only in IDLE. Its later deassertion never aborts an access.
- REQ: VRAM_REQ = 1 and VRAM_ADDR/VRAM_WE/VRAM_WDATA are driven from the latches.
  - On VRAM_GNT with write: go to ACK.
  - On VRAM_GNT with read: clear the timeout counter and go to WAIT_RD.
  - Without VRAM_GNT: stay in REQ indefinitely.
- WAIT_RD: VRAM_REQ = 0. VRAM_RVALID is honoured only in this state (an RVALID in the grant cycle is ignored).
  - On VRAM_RVALID: CMD_RDATA <= VRAM_RDATA, then go to ACK.
  - Otherwise the counter increments. When it reaches RD_TIMEOUT: CMD_RDATA <= 8'hFF, TIMEOUT_ERR <= 1, then go to ACK.
  - If RVALID arrives in the same cycle the counter reaches RD_TIMEOUT, RVALID wins and there is no error.
- ACK: CMD_ACK = 1 and DRIVE = 1 for exactly this cycle, then IDLE. Back-to-back accesses therefore need at least one IDLE cycle.
- Latency from the IDLE accept cycle (cycle 0):
  - Write with immediate grant: VRAM_REQ in cycle 1, ACK/DRIVE in cycle 2, next accept no earlier than cycle 3.
  - Read: ACK one cycle after the RVALID cycle.
- CMD_REQ is ignored outside IDLE. Changes to CMD_* inputs outside IDLE have no effect.
- CLR_ERR clears TIMEOUT_ERR. If a timeout occurs in the same cycle as CLR_ERR, the set wins.
- Exactly one DRIVE pulse per CMD_ACK. DRIVE never occurs without CMD_ACK.

Optional Feature:
VDP_ACCESS_STATS_EN
- Defined: adds output STALL_CNT [15:0]. It increments each cycle that the state is IDLE, CMD_REQ = 1 and ACTIVE = 0. It saturates at 16'hFFFF, resets to 0, and CLR_ERR clears it to 0 (clear wins over increment).
- Undefined: the STALL_CNT port is absent and no counter logic is built. All other behaviour is identical.

Test Plan:
- Write, immediate grant: ACTIVE = 1, CMD_REQ = 1, CMD_WR = 1, CMD_ADDR = 17'h1ABCD, WDATA = 8'h5A, GNT in cycle 1 -> VRAM_REQ only in cycle 1 with VRAM_ADDR = 17'h1ABCD, WE = 1, WDATA = 8'h5A; CMD_ACK and DRIVE both 1 only in cycle 2; BUSY 1 in cycles 1-2.
- Throttle: CMD_REQ = 1, ACTIVE = 0 for 10 cycles, then 1 -> no VRAM_REQ during the 10 cycles, accept on the first ACTIVE cycle; with VDP_ACCESS_STATS_EN, STALL_CNT = 10. ACTIVE dropping in REQ -> access still completes.
- Read: CMD_WR = 0, GNT after 3 REQ cycles, RVALID with RDATA = 8'hC3 three cycles later -> CMD_RDATA = 8'hC3 at ACK, one DRIVE pulse, TIMEOUT_ERR = 0.
- Read timeout, RD_TIMEOUT = 15, no RVALID -> ACK after 15 WAIT_RD cycles, CMD_RDATA = 8'hFF, TIMEOUT_ERR = 1 and stays 1 until CLR_ERR; RVALID on cycle 15 -> data accepted, no error.
- Reset mid-read: RESET_N low in WAIT_RD -> all outputs at reset values immediately, no ACK or DRIVE afterwards; after release, a new write completes normally.
- Streaming: CMD_REQ held high, ACTIVE = 1, GNT always 1, 8 writes -> 8 CMD_ACK and 8 DRIVE pulses, 3 cycles apart.
